// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and data memory (DM).
// DM has priority; a starvation counter forces an IF grant after STARVE_LIMIT back-to-back DM wins.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          o_grant,
    output logic [1:0]          dbg_state
);

    // Handshake: a requester holds req (and its operands, sampled only at grant) until its
    // one-cycle valid pulse; the memory finishes a transaction in the cycle mem_ready=1 while mem_req=1.

    localparam int          STRB_W = DATA_W / 8;
    localparam logic [3:0]  LIMIT  = 4'(STARVE_LIMIT);
    localparam logic [1:0]  GNT_IF = 2'b01;
    localparam logic [1:0]  GNT_DM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]        starve_cnt, starve_d;
    logic              flush_pending, flush_d;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
    logic [STRB_W-1:0] mem_wstrb_d;
    logic              if_valid_d, dm_valid_d;
    logic [1:0]        grant_d;
    logic              grant_dm, grant_if;

    assign grant_dm = (state_q == IDLE) && dm_req && ((starve_cnt < LIMIT) || !if_req);
    assign grant_if = (state_q == IDLE) && !grant_dm && if_req;

    assign if_stall  = if_req && !if_valid;
    assign dm_stall  = dm_req && !dm_valid;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_dm || grant_if) state_d = BUSY;
            BUSY:    if (mem_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_wstrb_d = mem_wstrb;
        if_rdata_d  = if_rdata;
        if_valid_d  = if_valid;
        dm_rdata_d  = dm_rdata;
        dm_valid_d  = dm_valid;
        grant_d     = o_grant;
        starve_d    = starve_cnt;
        flush_d     = flush_pending;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_wstrb_d = dm_wstrb;
                    grant_d     = GNT_DM;
                end else if (grant_if) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    grant_d     = GNT_IF;
                end
                // Only DM wins that overtake a waiting fetch count towards starvation.
                if (grant_dm && if_req)
                    starve_d = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
                else if (grant_if || !if_req)
                    starve_d = 4'd0;
            end
            BUSY: begin
                if (o_grant == GNT_IF && if_flush) flush_d = 1'b1;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (o_grant == GNT_DM) begin
                        dm_valid_d = 1'b1;
                        if (!mem_we) dm_rdata_d = mem_rdata;
                    end else if (!(flush_pending || if_flush)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                if_valid_d = 1'b0;
                dm_valid_d = 1'b0;
                grant_d    = 2'b00;
                flush_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            if_rdata      <= '0;
            if_valid      <= 1'b0;
            dm_rdata      <= '0;
            dm_valid      <= 1'b0;
            o_grant       <= 2'b00;
            starve_cnt    <= 4'd0;
            flush_pending <= 1'b0;
        end else begin
            mem_req       <= mem_req_d;
            mem_we        <= mem_we_d;
            mem_addr      <= mem_addr_d;
            mem_wdata     <= mem_wdata_d;
            mem_wstrb     <= mem_wstrb_d;
            if_rdata      <= if_rdata_d;
            if_valid      <= if_valid_d;
            dm_rdata      <= dm_rdata_d;
            dm_valid      <= dm_valid_d;
            o_grant       <= grant_d;
            starve_cnt    <= starve_d;
            flush_pending <= flush_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios push expected grants and read data,
// a monitor pops and compares whenever the DUT grants the port or pulses a valid.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
    logic [SW-1:0] dm_wstrb = '0;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic          if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_wstrb;
    logic [1:0]    o_grant, dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .o_grant(o_grant), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] if_exp_q[$];
    logic [DW-1:0] dm_exp_q[$];
    logic [70:0]   gnt_exp_q[$];
    int mem_wait = 0;
    bit mem_en = 1'b1;
    int wcnt = 0;
    logic [1:0]  mon_prev_g = 2'b00;
    logic [70:0] mon_lat = '0;

    function automatic logic [31:0] model_data(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [70:0] gent(input logic [1:0] g, input logic we, input logic [31:0] a,
                                         input logic [31:0] wd, input logic [3:0] ws);
        return {g, we, a, we ? wd : 32'h0, ws};
    endfunction

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Memory model: answers after mem_wait idle cycles of mem_req, data derived from the address.
    initial forever begin
        @(negedge clk);
        if (mem_ready) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else if (!mem_req) begin
            wcnt = 0;
        end else if (mem_en) begin
            if (wcnt >= mem_wait) begin
                mem_ready = 1'b1;
                mem_rdata = model_data(mem_addr);
            end else begin
                wcnt++;
            end
        end
    end

    // Monitor: grant order/operands, operand stability while busy, and returned data.
    initial forever begin
        @(negedge clk);
        if (o_grant != 2'b00 && mon_prev_g == 2'b00) begin
            mon_lat = gent(o_grant, mem_we, mem_addr, mem_wdata, mem_wstrb);
            if (gnt_exp_q.size() == 0) fail("grant_unexpected");
            else check("grant", mon_lat, gnt_exp_q.pop_front());
        end else if (o_grant != 2'b00 && mem_req) begin
            check("mem_stable", gent(o_grant, mem_we, mem_addr, mem_wdata, mem_wstrb), mon_lat);
        end
        mon_prev_g = o_grant;
        if (if_valid) begin
            if (if_exp_q.size() == 0) fail("if_valid_unexpected");
            else check("if_rdata", if_rdata, if_exp_q.pop_front());
        end
        if (dm_valid) begin
            if (dm_exp_q.size() == 0) fail("dm_valid_unexpected");
            else check("dm_rdata", dm_rdata, dm_exp_q.pop_front());
        end
    end

    task automatic fetch(input logic [31:0] a);
        int t;
        if_exp_q.push_back(model_data(a));
        if_addr = a;
        if_req  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!if_valid && t < 60);
        if (!if_valid) fail("fetch_timeout");
        if_req = 1'b0;
    endtask

    task automatic dm_load(input logic [31:0] a);
        int t;
        dm_exp_q.push_back(model_data(a));
        dm_addr = a;
        dm_we   = 1'b0;
        dm_req  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!dm_valid && t < 60);
        if (!dm_valid) fail("load_timeout");
        dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_ctl", {mem_req, mem_we, mem_wstrb, o_grant, dbg_state}, 0);
        check("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 0);
        check("rst_rdata", {if_rdata, dm_rdata}, 0);
        check("rst_valid_stall", {if_valid, dm_valid, if_stall, dm_stall}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single fetch, two wait cycles: valid in the 5th cycle after the request
        mem_wait = 2;
        if_exp_q.push_back(32'h0050_0093);
        gnt_exp_q.push_back(gent(2'b01, 1'b0, 32'h10, 32'h0, 4'h0));
        if_addr = 32'h10;
        if_req  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("fetch_valid", if_valid, (i == 4) ? 1 : 0);
            check("fetch_stall", if_stall, (i != 4) ? 1 : 0);
            check("fetch_mem_req", mem_req, (i != 4) ? 1 : 0);
        end
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_pulse_end", {if_valid, o_grant, dbg_state}, 0);

        // Simultaneous IF and DM load: DM first
        mem_wait = 1;
        gnt_exp_q.push_back(gent(2'b10, 1'b0, 32'h100, 32'h0, 4'h0));
        gnt_exp_q.push_back(gent(2'b01, 1'b0, 32'h14, 32'h0, 4'h0));
        fork
            fetch(32'h14);
            dm_load(32'h100);
        join
        @(negedge clk);

        // Store: operands changed after grant must be ignored, dm_rdata keeps the last load
        mem_wait = 3;
        dm_exp_q.push_back(model_data(32'h100));
        gnt_exp_q.push_back(gent(2'b10, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF));
        dm_we    = 1'b1;
        dm_addr  = 32'h20;
        dm_wdata = 32'hDEAD_BEEF;
        dm_wstrb = 4'hF;
        dm_req   = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            check("store_stall", dm_stall, !dm_valid);
            if (t == 2) begin
                dm_addr  = 32'hBAD0;
                dm_wdata = 32'h0;
                dm_wstrb = 4'h0;
            end
        end while (!dm_valid && t < 60);
        if (!dm_valid) fail("store_timeout");
        dm_req = 1'b0;
        dm_we  = 1'b0;
        @(negedge clk);

        // Starvation: 4 DM grants, IF, 4 more DM grants (counter restarted), IF, DM
        mem_wait = 0;
        for (int i = 0; i < 9; i++) begin
            gnt_exp_q.push_back(gent(2'b10, 1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'h0));
            if (i == 3) gnt_exp_q.push_back(gent(2'b01, 1'b0, 32'h40, 32'h0, 4'h0));
            if (i == 7) gnt_exp_q.push_back(gent(2'b01, 1'b0, 32'h44, 32'h0, 4'h0));
        end
        fork
            begin
                fetch(32'h40);
                fetch(32'h44);
            end
            begin
                for (int i = 0; i < 9; i++) dm_load(32'h200 + 32'(4 * i));
            end
        join
        @(negedge clk);

        // Flush during an IF transaction: no valid, if_rdata kept, port recovers
        mem_wait = 1;
        gnt_exp_q.push_back(gent(2'b01, 1'b0, 32'h48, 32'h0, 4'h0));
        if_addr = 32'h48;
        if_req  = 1'b1;
        @(negedge clk);
        check("flush_owner", o_grant, 2'b01);
        if_flush = 1'b1;
        if_req   = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_no_valid", if_valid, 0);
        end
        check("flush_rdata_kept", if_rdata, model_data(32'h44));
        check("flush_idle", dbg_state, 2'd0);
        mem_wait = 0;
        gnt_exp_q.push_back(gent(2'b01, 1'b0, 32'h4C, 32'h0, 4'h0));
        fetch(32'h4C);
        @(negedge clk);

        // Reset in the middle of a busy transaction
        mem_en = 1'b0;
        gnt_exp_q.push_back(gent(2'b01, 1'b0, 32'h80, 32'h0, 4'h0));
        if_addr = 32'h80;
        if_req  = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_before_reset", {dbg_state, mem_req}, {2'd1, 1'b1});
        reset  = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        check("midrst_mem_ctl", {mem_req, mem_we, mem_wstrb, o_grant, dbg_state}, 0);
        check("midrst_mem_addr", {mem_addr, mem_wdata}, 0);
        check("midrst_rdata", {if_rdata, dm_rdata}, 0);
        @(negedge clk);
        reset  = 1'b1;
        mem_en = 1'b1;
        check("midrst_valid", {if_valid, dm_valid, mem_req}, 0);
        repeat (4) @(negedge clk);
        check("midrst_idle", {dbg_state, o_grant, if_valid, mem_req}, 0);

        check("if_queue_drained", 71'(if_exp_q.size()), 0);
        check("dm_queue_drained", 71'(dm_exp_q.size()), 0);
        check("grant_queue_drained", 71'(gnt_exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) requester and data-memory (MEM stage, DM) requester.
- Arbitrates between them, sequences a multi-cycle ready/valid transaction on the memory port, and returns read data with a one-cycle valid pulse.
- Generates per-requester stall signals for the hazard/stall logic.
- Data requests have priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- STARVE_LIMIT, 4, consecutive DM grants with if_req pending after which IF wins the next arbitration (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  discard the outstanding fetch (branch taken)
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle pulse, if_rdata valid
- if_stall  out  1  if_req && !if_valid (combinational)
- dm_req  in  1  data request; held high until dm_valid
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wstrb  in  DATA_W/8  store byte enables
- dm_rdata  out  DATA_W  load data
- dm_valid  out  1  one-cycle pulse, load data valid / store acknowledged
- dm_stall  out  1  dm_req && !dm_valid (combinational)
- mem_req  out  1  memory transaction active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte enables
- mem_ready  in  1  memory completes the current transaction this cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- o_grant  out  2  debug: 00 none, 01 IF owns port, 10 DM owns port

Behaviour:
- FSM states: IDLE, BUSY, DONE. All outputs are registered except the stalls.
- Reset values: state IDLE; all of the following are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rdata, if_valid, dm_rdata, dm_valid, o_grant, the starvation counter, and the flush-pending flag.
- IDLE, arbitration:
  - If dm_req && (starve_cnt < STARVE_LIMIT || !if_req): grant DM.
  - Else if if_req: grant IF.
  - Else: stay in IDLE.
- On a grant: latch owner, address, we, wdata and wstrb into the mem_* registers, set mem_req=1 and o_grant, then go to BUSY.
  - IF grants drive mem_we=0 and mem_wstrb=0.
- Starvation counter:
  - A DM grant while if_req=1 increments starve_cnt, saturating at STARVE_LIMIT.
  - An IF grant, or arbitration with if_req=0, clears it.
- BUSY: the mem_* outputs stay stable until mem_ready=1. On mem_ready:
  - mem_req=0, go to DONE.
  - DM owner: dm_valid=1 next cycle; dm_rdata<=mem_rdata on loads only; dm_rdata unchanged on stores.
  - IF owner: if_rdata<=mem_rdata and if_valid=1, unless flush_pending.
- DONE: the valid pulse is high for exactly this cycle. Clear o_grant and flush_pending, then go to IDLE.
  - No arbitration happens in DONE, so the requester's still-high req is never re-granted.
- Latency:
  - Grant at cycle 0; mem_req high from cycle 1.
  - With mem_ready in cycle k, valid is high in cycle k+1.
  - The next grant is possible in cycle k+2; the minimum occupancy is 3 cycles per access with zero-wait memory (ready in the first mem_req cycle).
- if_flush:
  - In BUSY with IF owner, or coincident with mem_ready: set flush_pending. The memory transaction completes normally, but if_valid stays 0 and if_rdata is unchanged.
  - In IDLE or DONE, or while DM owns the port: no effect.
  - The fetch unit re-requests the new address through if_req.
- mem_ready is ignored in IDLE and DONE.
- Simultaneous requests: DM wins unless starve_cnt==STARVE_LIMIT. Exactly one owner at any time.
- Reset mid-transaction: all registers clear at the edge, mem_req is low the following cycle, and no valid is issued. The memory model abandons the transaction.
- Requester addresses and data are sampled only at grant; changes afterwards are ignored.

Test Plan:
- Reset: hold reset=0 for 2 cycles during an active BUSY -> every output 0, o_grant=00, mem_req low the cycle after the reset edge.
- Single fetch: if_req=1, if_addr=0x10, mem_ready after 2 wait cycles with mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0; if_valid pulses one cycle with if_rdata=0x00500093; if_stall high until the pulse; 5-cycle total.
- Conflict: if_req and dm_req (load 0x100) asserted the same cycle -> DM granted first (o_grant=10); IF granted at the next IDLE; dm_rdata matches mem_rdata.
- Store: dm_we=1, dm_addr=0x20, wdata=0xDEADBEEF, wstrb=0xF -> mem outputs stable until mem_ready; dm_valid pulses; dm_rdata unchanged.
- Starvation: dm_req held continuously with if_req=1, STARVE_LIMIT=4 -> exactly 4 DM grants, then 1 IF grant, and the counter resets.
- Flush: IF owns the port, if_flush pulses in BUSY, mem_ready 1 cycle later -> no if_valid, if_rdata unchanged, FSM returns to IDLE after DONE.
